// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// Parallel-load universal shift register with a built-in serial transmitter.
// While idle, the register holds, loads, shifts or rotates under control of
// `mode`. A `start` request sends the current contents out on `ser_out`,
// LSB first, over WIDTH cycles. `busy` is high for those cycles. A single
// `done` cycle follows, and then the block returns to idle.
//
// Parameters
//   WIDTH    register width in bits (2..64)
//   RST_VAL  data_out value after reset
//
// Ports
//   clk       in   system clock, all state changes on its rising edge
//   sync_rst  in   synchronous active-high reset, overrides everything
//   mode      in   [2:0] idle operation select (ignored unless idle, start=0)
//   data_in   in   [WIDTH-1:0] parallel load data
//   ser_in_l  in   fill bit entering the LSB on shift-left
//   ser_in_r  in   fill bit entering the MSB on shift-right and transmit
//   start     in   request a serial transmit of data_out
//   data_out  out  [WIDTH-1:0] registered register contents
//   ser_out   out  always data_out[0]
//   busy      out  registered, high while transmitting
//   done      out  registered, one-cycle pulse after a transmit
// -----------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Right shift with an external MSB fill. Shared by idle mode 011 and
    // every transmit cycle.
    function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] v,
                                                  input logic             fill);
        return {fill, v[WIDTH-1:1]};
    endfunction

    // Next-state logic for the controller, the bit counter and the data register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Launch a transfer. The data is sent as it stands, so mode is ignored.
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    case (mode)
                        MODE_HOLD: data_d = data_q;
                        MODE_LOAD: data_d = data_in;
                        MODE_SHL:  data_d = {data_q[WIDTH-2:0], ser_in_l};
                        MODE_SHR:  data_d = shr_fill(data_q, ser_in_r);
                        MODE_ROL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                        MODE_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
                        default:   data_d = data_q;
                    endcase
                end
            end
            ST_SHIFT: begin
                data_d = shr_fill(data_q, ser_in_r);
                if (cnt_q == CNT_LAST) begin
                    // Final shift. The counter is left at its last value so it never wraps.
                    state_d = ST_DONE;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = ST_SHIFT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Status flags are decoded from the next state so they line up with it once registered.
    always_comb begin
        busy_d = (state_d == ST_SHIFT) ? 1'b1 : 1'b0;
        done_d = (state_d == ST_DONE)  ? 1'b1 : 1'b0;
    end

    // State register with synchronous reset, which takes priority over all activity.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            data_q  <= RST_VAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign ser_out  = data_q[0];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, RST_VAL=8'h5A, checked every cycle against the model.
    logic       rst_a, sl_a, sr_a, start_a;
    logic [2:0] mode_a;
    logic [7:0] din_a;
    logic [7:0] dout_a;
    logic       sout_a, busy_a, done_a;

    // Instance B: WIDTH=16, RST_VAL=0, directed transfer only.
    logic        rst_b, sl_b, sr_b, start_b;
    logic [2:0]  mode_b;
    logic [15:0] din_b;
    logic [15:0] dout_b;
    logic        sout_b, busy_b, done_b;

    universal_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A)) dut_a (
        .clk(clk), .sync_rst(rst_a), .mode(mode_a), .data_in(din_a),
        .ser_in_l(sl_a), .ser_in_r(sr_a), .start(start_a),
        .data_out(dout_a), .ser_out(sout_a), .busy(busy_a), .done(done_a)
    );

    universal_shift_reg #(.WIDTH(16), .RST_VAL(16'h0000)) dut_b (
        .clk(clk), .sync_rst(rst_b), .mode(mode_b), .data_in(din_b),
        .ser_in_l(sl_b), .ser_in_r(sr_b), .start(start_b),
        .data_out(dout_b), .ser_out(sout_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model for instance A. The register is a plain integer 0..255,
    // and a transfer is a countdown of bits still to send.
    int unsigned m_data = 0;
    int          m_left = 0;
    bit          m_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst_a) begin
            m_data = 32'h5A;
            m_left = 0;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_data = m_data / 2 + 128 * int'(sr_a);
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start_a) begin
            m_left = 8;
        end else begin
            case (mode_a)
                3'd1: m_data = int'(din_a);
                3'd2: m_data = (m_data * 2) % 256 + int'(sl_a);
                3'd3: m_data = m_data / 2 + 128 * int'(sr_a);
                3'd4: m_data = (m_data * 2) % 256 + m_data / 128;
                3'd5: m_data = m_data / 2 + (m_data % 2) * 128;
                default: m_data = m_data;
            endcase
        end
    endtask

    // One clock: predict, take the edge, then compare all of instance A's outputs.
    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ":data"}, 64'(dout_a), 64'(m_data));
        chk({tag, ":ser"},  64'(sout_a), 64'(m_data % 2));
        chk({tag, ":busy"}, 64'(busy_a), 64'(m_left > 0));
        chk({tag, ":done"}, 64'(done_a), 64'(m_done));
    endtask

    int          nbusy, ndone;
    logic [7:0]  seq_a;
    logic [15:0] seq_b;

    initial begin
        rst_a = 1'b1; mode_a = 3'd0; din_a = 8'h00; sl_a = 1'b0; sr_a = 1'b0; start_a = 1'b0;
        rst_b = 1'b1; mode_b = 3'd0; din_b = 16'h0000; sl_b = 1'b0; sr_b = 1'b0; start_b = 1'b0;

        // Reset state
        cyc("rst");
        chk("rst_val", 64'(dout_a), 64'h5A);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_done", 64'(done_a), 64'h0);
        rst_a = 1'b0;

        // Load and hold
        mode_a = 3'd1; din_a = 8'hA5; cyc("load");
        chk("load_a5", 64'(dout_a), 64'hA5);
        mode_a = 3'd0;
        for (int i = 0; i < 3; i++) cyc("hold");
        chk("hold_a5", 64'(dout_a), 64'hA5);

        // Rotates and shifts from 8'h81
        mode_a = 3'd1; din_a = 8'h81; cyc("ld81");
        mode_a = 3'd4; cyc("rol");
        chk("rol_03", 64'(dout_a), 64'h03);
        mode_a = 3'd5; cyc("ror");
        chk("ror_81", 64'(dout_a), 64'h81);
        mode_a = 3'd2; sl_a = 1'b1; cyc("shl");
        chk("shl_03", 64'(dout_a), 64'h03);
        mode_a = 3'd1; din_a = 8'h81; cyc("ld81b");
        mode_a = 3'd3; sr_a = 1'b0; cyc("shr");
        chk("shr_40", 64'(dout_a), 64'h40);
        mode_a = 3'd6; cyc("m110");
        chk("m110_hold", 64'(dout_a), 64'h40);

        // Serial transmit of 8'hB4 with ser_in_r=1
        mode_a = 3'd1; din_a = 8'hB4; cyc("ldb4");
        mode_a = 3'd0; sr_a = 1'b1; start_a = 1'b1; cyc("tx_start");
        start_a = 1'b0;
        nbusy = 0; seq_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (busy_a) begin
                seq_a[i] = sout_a;
                nbusy++;
            end
            cyc("tx");
        end
        chk("tx_busy_cycles", 64'(nbusy), 64'd8);
        chk("tx_ser_seq", 64'(seq_a), 64'hB4);
        chk("tx_done", 64'(done_a), 64'h1);
        chk("tx_final", 64'(dout_a), 64'hFF);
        cyc("tx_idle");
        chk("tx_idle_done", 64'(done_a), 64'h0);
        chk("tx_idle_busy", 64'(busy_a), 64'h0);

        // Start held high for 20 cycles while mode toggles
        mode_a = 3'd1; din_a = 8'h0F; sr_a = 1'b0; cyc("ld0f");
        start_a = 1'b1; nbusy = 0; ndone = 0;
        for (int i = 0; i < 20; i++) begin
            mode_a = 3'($urandom);
            din_a  = 8'($urandom);
            cyc("held");
            if (busy_a) nbusy++;
            if (done_a) ndone++;
            chk("held_excl", 64'(busy_a & done_a), 64'h0);
        end
        chk("held_busy", 64'(nbusy), 64'd16);
        chk("held_done", 64'(ndone), 64'd2);
        start_a = 1'b0; mode_a = 3'd0;

        // Reset during the 4th SHIFT cycle
        mode_a = 3'd1; din_a = 8'h3C; cyc("ld3c");
        mode_a = 3'd0; start_a = 1'b1; cyc("mid1");
        start_a = 1'b0; cyc("mid2"); cyc("mid3"); cyc("mid4");
        chk("mid_busy4", 64'(busy_a), 64'h1);
        rst_a = 1'b1; cyc("mid_rst");
        chk("mid_rst_val", 64'(dout_a), 64'h5A);
        chk("mid_rst_busy", 64'(busy_a), 64'h0);
        chk("mid_rst_done", 64'(done_a), 64'h0);
        rst_a = 1'b0; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            cyc("post_rst");
            if (done_a) ndone++;
        end
        chk("post_rst_no_done", 64'(ndone), 64'd0);

        // Randomized operation against the model
        for (int i = 0; i < 400; i++) begin
            rst_a   = ($urandom_range(63) == 0);
            mode_a  = 3'($urandom);
            din_a   = 8'($urandom);
            sl_a    = 1'($urandom);
            sr_a    = 1'($urandom);
            start_a = ($urandom_range(5) == 0);
            cyc("rnd");
            chk("rnd_excl", 64'(busy_a & done_a), 64'h0);
        end
        rst_a = 1'b0; start_a = 1'b0; mode_a = 3'd0;

        // WIDTH=16 transfer of 16'h8001
        rst_b = 1'b1; cyc("b_rst");
        chk("b_rst_val", 64'(dout_b), 64'h0000);
        rst_b = 1'b0; mode_b = 3'd1; din_b = 16'h8001; cyc("b_load");
        chk("b_load", 64'(dout_b), 64'h8001);
        mode_b = 3'd0; sr_b = 1'b0; start_b = 1'b1; cyc("b_start");
        start_b = 1'b0;
        nbusy = 0; seq_b = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (busy_b) begin
                seq_b[i] = sout_b;
                nbusy++;
            end
            cyc("b_tx");
        end
        chk("b_busy_cycles", 64'(nbusy), 64'd16);
        chk("b_ser_seq", 64'(seq_b), 64'h8001);
        chk("b_done", 64'(done_b), 64'h1);
        chk("b_done_busy", 64'(busy_b), 64'h0);
        chk("b_final", 64'(dout_b), 64'h0000);
        cyc("b_idle");
        chk("b_idle_done", 64'(done_b), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
